instr_fetch_queue: RTL and testbench

- Parametrised successor to the single-PC fetch path: owns the fetch PC and issues pipelined instruction-memory requests under a valid/ready handshake.
- Buffers in-order responses in a DEPTH-entry queue, each entry tagged with its PC.
- Presents instructions to the decoder via valid/ready.
- A redirect (branch/jump) flushes the queue and discards stale in-flight responses.

---
 rtl/instr_fetch_queue_if.sv | 33 +++
 rtl/instr_fetch_queue.sv | 116 +++++++++++
 tb/tb_instr_fetch_queue.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Fetch-side bus bundle: instruction-memory request/response,
// redirect input and the decoder-facing instruction handshake.
interface instr_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                     o_imemReqValid;
    logic [XLEN-1:0]          o_imemAddr;
    logic                     i_imemReqReady;
    logic                     i_imemRspValid;
    logic [31:0]              i_imemData;
    logic                     i_redirectValid;
    logic [XLEN-1:0]          i_redirectPC;
    logic                     o_instrValid;
    logic [31:0]              o_instr;
    logic [XLEN-1:0]          o_instrPC;
    logic                     i_instrReady;
    logic [$clog2(DEPTH):0]   o_inflight;

    // Fetch unit side
    modport master (
        output o_imemReqValid, o_imemAddr, o_instrValid, o_instr, o_instrPC, o_inflight,
        input  i_imemReqReady, i_imemRspValid, i_imemData, i_redirectValid, i_redirectPC,
               i_instrReady
    );

    // Memory / decoder / branch-unit side
    modport slave (
        input  o_imemReqValid, o_imemAddr, o_instrValid, o_instr, o_instrPC, o_inflight,
        output i_imemReqReady, i_imemRspValid, i_imemData, i_redirectValid, i_redirectPC,
               i_instrReady
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues pipelined memory
// requests, buffers in-order responses tagged with their PC and hands
// them to the decoder. A redirect flushes the queue and arranges for
// responses to already-issued requests to be discarded.
module instr_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    instr_fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [31:0]     q_instr [DEPTH];
    logic [DEPTH-1:0] q_filled;

    ptr_t head_ptr;
    ptr_t alloc_ptr;
    ptr_t fill_ptr;

    // alloc_cnt: reserved + filled entries; pend_cnt: reserved but not yet filled
    cnt_t alloc_cnt;
    cnt_t pend_cnt;
    cnt_t drop_cnt;

    logic          redirect;
    logic [CW:0]   budget;
    logic          req_valid;
    logic          accept;
    logic          fill;
    logic          discard;
    logic          instr_valid;
    logic          pop;
    cnt_t          drop_after_redirect;

    assign redirect = bus.i_redirectValid;

    // Handshake qualifiers and redirect drop bookkeeping
    always_comb begin
        budget              = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
        req_valid           = !i_reset && !redirect && (budget < (CW+1)'(DEPTH));
        accept              = req_valid && bus.i_imemReqReady;
        discard             = bus.i_imemRspValid && (drop_cnt != '0);
        fill                = bus.i_imemRspValid && (drop_cnt == '0) && !redirect && !i_reset;
        instr_valid         = !i_reset && !redirect && q_filled[head_ptr] && (alloc_cnt != '0);
        pop                 = instr_valid && bus.i_instrReady;
        // A response landing in the redirect cycle retires one outstanding request
        drop_after_redirect = pend_cnt + drop_cnt - cnt_t'(bus.i_imemRspValid);
    end

    assign bus.o_imemReqValid = req_valid;
    assign bus.o_imemAddr     = fetch_pc;
    assign bus.o_instrValid   = instr_valid;
    assign bus.o_instr        = instr_valid ? q_instr[head_ptr] : '0;
    assign bus.o_instrPC      = instr_valid ? q_pc[head_ptr]    : '0;
    assign bus.o_inflight     = i_reset ? '0 : pend_cnt + drop_cnt;

    // Fetch PC, pointers, occupancy and drop counters
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            fetch_pc  <= RESET_PC;
            head_ptr  <= '0;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= '0;
            q_filled  <= '0;
        end else if (redirect) begin
            fetch_pc  <= bus.i_redirectPC;
            head_ptr  <= '0;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= drop_after_redirect;
            q_filled  <= '0;
        end else begin
            if (accept) begin
                q_filled[alloc_ptr] <= 1'b0;
                alloc_ptr           <= alloc_ptr + ptr_t'(1);
                fetch_pc            <= fetch_pc + XLEN'(4);
            end
            if (discard) begin
                drop_cnt <= drop_cnt - cnt_t'(1);
            end
            if (fill) begin
                q_filled[fill_ptr] <= 1'b1;
                fill_ptr           <= fill_ptr + ptr_t'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + ptr_t'(1);
            end
            alloc_cnt <= alloc_cnt + cnt_t'(accept) - cnt_t'(pop);
            pend_cnt  <= pend_cnt  + cnt_t'(accept) - cnt_t'(fill);
        end
    end

    // Queue payload storage: PC tag on reservation, instruction word on fill
    always_ff @(posedge i_clock) begin
        if (accept) begin
            q_pc[alloc_ptr] <= fetch_pc;
        end
        if (fill) begin
            q_instr[fill_ptr] <= bus.i_imemData;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: a memory model with
// configurable latency, a scoreboard of expected {pc, word} pushed on
// request acceptance and popped when the decoder takes an instruction,
// plus directed checks for stall, hold, redirect, wrap and reset cases.
module tb_instr_fetch_queue;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instr_fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

    instr_fetch_queue #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mem_req_t;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    mem_req_t    mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] acc_log[$];

    logic        mem_ready;
    logic        dec_ready;
    logic        redir;
    logic [31:0] redir_pc;
    int unsigned mem_lat;
    int unsigned cyc = 0;
    logic [31:0] model_pc;
    int unsigned n_acc;
    int unsigned n_pop;
    int          since_rst;
    int          first_valid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // One clock cycle: drive inputs from knobs, sample and update model, then advance.
    task automatic step(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            int unsigned exp_inflight;
            logic        acc;
            logic        pp;
            logic [31:0] e;
            mem_req_t    r;
            cyc++;
            if (rst) begin
                mem_q.delete();
                exp_q.delete();
            end
            bus.i_imemReqReady  = mem_ready;
            bus.i_instrReady    = dec_ready;
            bus.i_redirectValid = redir;
            bus.i_redirectPC    = redir_pc;
            exp_inflight        = mem_q.size();
            if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                bus.i_imemRspValid = 1'b1;
                bus.i_imemData     = mem_word(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                bus.i_imemRspValid = 1'b0;
                bus.i_imemData     = $urandom;
            end
            #1;
            check_eq("inflight", 32'(bus.o_inflight), exp_inflight);
            if (!bus.o_instrValid)
                check_eq("idle_outputs", bus.o_instr | bus.o_instrPC, 32'h0);
            if (rst) begin
                check_eq("rst_req_valid", {31'b0, bus.o_imemReqValid}, 32'd0);
                check_eq("rst_instr_valid", {31'b0, bus.o_instrValid}, 32'd0);
                model_pc    = RST_PC;
                since_rst   = 0;
                first_valid = -1;
            end else begin
                if (redir) begin
                    check_eq("redir_req_valid", {31'b0, bus.o_imemReqValid}, 32'd0);
                    check_eq("redir_instr_valid", {31'b0, bus.o_instrValid}, 32'd0);
                end
                if (bus.o_imemReqValid)
                    check_eq("imem_addr", bus.o_imemAddr, model_pc);
                if (bus.o_instrValid && first_valid < 0)
                    first_valid = since_rst;
                acc = bus.o_imemReqValid && mem_ready;
                pp  = bus.o_instrValid && dec_ready;
                if (redir) begin
                    exp_q.delete();
                    model_pc = redir_pc;
                end else begin
                    if (pp) begin
                        check_eq("pop_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check_eq("instr_pc", bus.o_instrPC, e);
                            check_eq("instr_word", bus.o_instr, mem_word(e));
                        end
                        pop_log.push_back(bus.o_instrPC);
                        n_pop++;
                    end
                    if (acc) begin
                        exp_q.push_back(model_pc);
                        r.addr = model_pc;
                        r.due  = cyc + mem_lat;
                        mem_q.push_back(r);
                        acc_log.push_back(model_pc);
                        model_pc = model_pc + 32'd4;
                        n_acc++;
                    end
                end
                since_rst++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        int unsigned stale;
        rst       = 1'b1;
        mem_ready = 1'b1;
        dec_ready = 1'b1;
        redir     = 1'b0;
        redir_pc  = '0;
        mem_lat   = 1;
        n_acc     = 0;
        n_pop     = 0;
        since_rst = 0;
        first_valid = -1;
        model_pc  = RST_PC;
        bus.i_imemReqReady  = 1'b0;
        bus.i_imemRspValid  = 1'b0;
        bus.i_imemData      = '0;
        bus.i_redirectValid = 1'b0;
        bus.i_redirectPC    = '0;
        bus.i_instrReady    = 1'b0;

        // Reset state
        step(3);
        rst = 1'b0;
        #1;
        check_eq("post_rst_addr", bus.o_imemAddr, RST_PC);
        check_eq("post_rst_instr", bus.o_instr, 32'h0);
        check_eq("post_rst_instr_pc", bus.o_instrPC, 32'h0);

        // Streaming: one instruction per cycle, first valid two cycles after reset
        pop_log.delete();
        n_pop = 0;
        step(20);
        check_eq("first_valid_latency", 32'(first_valid), 32'd2);
        check_eq("stream_pops", n_pop, 32'd18);
        if (pop_log.size() >= 18) begin
            check_eq("stream_first_pc", pop_log[0], 32'h0);
            check_eq("stream_last_pc", pop_log[17], 32'h44);
        end

        // Decoder stall: queue fills with exactly DEPTH requests
        do_reset();
        dec_ready = 1'b0;
        n_acc = 0;
        step(10);
        check_eq("stall_accepts", n_acc, 32'(DEPTH));
        check_eq("stall_req_low", {31'b0, bus.o_imemReqValid}, 32'd0);
        dec_ready = 1'b1;
        pop_log.delete();
        acc_log.delete();
        step(3);
        check_eq("resume_pop_count", {31'b0, pop_log.size() != 0}, 32'd1);
        if (pop_log.size() != 0) check_eq("resume_first_pop", pop_log[0], 32'h0);
        check_eq("resume_acc_count", {31'b0, acc_log.size() != 0}, 32'd1);
        if (acc_log.size() != 0) check_eq("resume_first_req", acc_log[0], 32'h10);

        // Memory not ready: address held
        do_reset();
        step(2);
        mem_ready = 1'b0;
        step(3);
        check_eq("hold_addr", bus.o_imemAddr, 32'h8);
        check_eq("hold_req_valid", {31'b0, bus.o_imemReqValid}, 32'd1);
        mem_ready = 1'b1;
        acc_log.delete();
        step(2);
        if (acc_log.size() >= 2) begin
            check_eq("hold_acc0", acc_log[0], 32'h8);
            check_eq("hold_acc1", acc_log[1], 32'hC);
        end else begin
            check_eq("hold_acc_count", acc_log.size(), 32'd2);
        end

        // Redirect with two in flight and a response in the redirect cycle
        do_reset();
        mem_lat = 2;
        step(2);
        redir    = 1'b1;
        redir_pc = 32'h100;
        step(1);
        redir = 1'b0;
        check_eq("redir_inflight", 32'(bus.o_inflight), 32'd1);
        pop_log.delete();
        step(8);
        check_eq("redir_pops", {31'b0, pop_log.size() != 0}, 32'd1);
        if (pop_log.size() != 0) check_eq("redir_first_pc", pop_log[0], 32'h100);
        stale = 0;
        foreach (pop_log[i]) if (pop_log[i] < 32'h100) stale++;
        check_eq("redir_stale_pcs", stale, 32'd0);

        // Wrap of the fetch PC past the top of the address space
        mem_lat  = 1;
        redir    = 1'b1;
        redir_pc = 32'hFFFF_FFF8;
        step(1);
        redir = 1'b0;
        pop_log.delete();
        step(6);
        if (pop_log.size() >= 3) begin
            check_eq("wrap_pc0", pop_log[0], 32'hFFFF_FFF8);
            check_eq("wrap_pc1", pop_log[1], 32'hFFFF_FFFC);
            check_eq("wrap_pc2", pop_log[2], 32'h0);
        end else begin
            check_eq("wrap_pop_count", pop_log.size(), 32'd3);
        end

        // Reset with three queued entries
        dec_ready = 1'b0;
        redir     = 1'b1;
        redir_pc  = 32'h200;
        step(1);
        redir = 1'b0;
        step(4);
        check_eq("queued_valid", {31'b0, bus.o_instrValid}, 32'd1);
        check_eq("queued_head_pc", bus.o_instrPC, 32'h200);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        check_eq("midrst_addr", bus.o_imemAddr, RST_PC);
        check_eq("midrst_valid", {31'b0, bus.o_instrValid}, 32'd0);
        check_eq("midrst_inflight", 32'(bus.o_inflight), 32'd0);
        dec_ready = 1'b1;
        pop_log.delete();
        step(5);
        if (pop_log.size() != 0) check_eq("midrst_first_pc", pop_log[0], RST_PC);
        else check_eq("midrst_pop_count", pop_log.size(), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
